// File: rtl/timer_run_if.sv
// -----------------------------------------------------------------------------
// timer_run_if
// Groups the timer/stopwatch controller's front-panel inputs and status outputs.
//   master : drives the raw buttons and preset, observes the status outputs
//   slave  : the controller itself
// Signals:
//   modeInput, startOrStop, splitOrReset  raw buttons, active high
//   presetCentiseconds                    countdown preset
//   mode, timerState                      display mode, countdown FSM state
//   remainingCount, stopwatchCount        centisecond counters
//   lapValue, lapStrobe                   captured split and its update pulse
//   ringSound                             alarm drive
// -----------------------------------------------------------------------------
interface timer_run_if #(
  parameter int CW = 32
);
  logic          modeInput;
  logic          startOrStop;
  logic          splitOrReset;
  logic [CW-1:0] presetCentiseconds;
  logic [1:0]    mode;
  logic [1:0]    timerState;
  logic [CW-1:0] remainingCount;
  logic [CW-1:0] stopwatchCount;
  logic [CW-1:0] lapValue;
  logic          lapStrobe;
  logic          ringSound;

  modport master (
    output modeInput, startOrStop, splitOrReset, presetCentiseconds,
    input  mode, timerState, remainingCount, stopwatchCount, lapValue,
           lapStrobe, ringSound
  );

  modport slave (
    input  modeInput, startOrStop, splitOrReset, presetCentiseconds,
    output mode, timerState, remainingCount, stopwatchCount, lapValue,
           lapStrobe, ringSound
  );
endinterface

// File: rtl/timer_run_controller.sv
// -----------------------------------------------------------------------------
// timer_run_controller
// Control sequencer for the 100 Hz timekeeping datapath: debounces the three
// front-panel buttons, cycles the display mode, and runs the countdown timer
// and stopwatch. All state is registered on the rising edge of clockSignal.
// Ports:
//   clockSignal  100 Hz system clock
//   resetN       synchronous active-low reset (overrides everything)
//   bus          timer_run_if slave: raw buttons, preset, and all status outputs
// Build option:
//   TIMER_AUTO_RELOAD_EN  when defined, the countdown reloads the last preset on
//                         expiry and keeps running while the ring pulses.
// -----------------------------------------------------------------------------
module timer_run_controller #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int RING_CYCLES     = 500,
  parameter int CW              = 32
) (
  input logic        clockSignal,
  input logic        resetN,
  timer_run_if.slave bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RBW = $clog2(RING_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RBW-1:0] RING_LAST = RBW'(RING_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_RING  = 2'd3;

  localparam logic [1:0] MODE_TIMER     = 2'd0;
  localparam logic [1:0] MODE_STOPWATCH = 2'd1;

  logic [2:0]     rawButtons_s;
  logic [DBW-1:0] debounceCount_r [3];
  logic [2:0]     pressEvent_s;
  logic           modePress_s;
  logic           timerStart_s;
  logic           timerSplit_s;
  logic           swStart_s;
  logic           swSplit_s;

  logic [1:0]     mode_r;
  logic [1:0]     timerState_r;
  logic [CW-1:0]  remainingCount_r;
  logic [RBW-1:0] ringCount_r;
  logic           ringSound_r;
  logic           swRunning_r;
  logic [CW-1:0]  stopwatchCount_r;
  logic [CW-1:0]  lapValue_r;
  logic           lapStrobe_r;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [CW-1:0]  presetHold_r;
`endif

  assign rawButtons_s = {bus.splitOrReset, bus.startOrStop, bus.modeInput};

  // Per-button debounce counters, saturating at DEBOUNCE_CYCLES
  always_ff @(posedge clockSignal) begin
    for (int i = 0; i < 3; i++) begin
      if (!resetN) begin
        debounceCount_r[i] <= DBW'(0);
      end else if (rawButtons_s[i]) begin
        if (debounceCount_r[i] != DB_MAX) begin
          debounceCount_r[i] <= debounceCount_r[i] + DBW'(1);
        end
      end else begin
        debounceCount_r[i] <= DBW'(0);
      end
    end
  end

  // Press events fire in the cycle the counter first reaches DEBOUNCE_CYCLES;
  // start beats split, and actions are routed by the mode held before this edge
  always_comb begin
    pressEvent_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (rawButtons_s[i] && (debounceCount_r[i] == DB_LAST)) begin
        pressEvent_s[i] = 1'b1;
      end else begin
        pressEvent_s[i] = 1'b0;
      end
    end
    modePress_s  = pressEvent_s[0];
    timerStart_s = pressEvent_s[1] && (mode_r == MODE_TIMER);
    timerSplit_s = pressEvent_s[2] && !pressEvent_s[1] && (mode_r == MODE_TIMER);
    swStart_s    = pressEvent_s[1] && (mode_r == MODE_STOPWATCH);
    swSplit_s    = pressEvent_s[2] && !pressEvent_s[1] && (mode_r == MODE_STOPWATCH);
  end

  // Display mode register, wrapping 3 -> 0
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      mode_r <= MODE_TIMER;
    end else if (modePress_s) begin
      mode_r <= mode_r + 2'd1;
    end
  end

  // Countdown FSM, remaining counter and ring timing
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      timerState_r     <= ST_IDLE;
      remainingCount_r <= CW'(0);
      ringSound_r      <= 1'b0;
      ringCount_r      <= RBW'(0);
`ifdef TIMER_AUTO_RELOAD_EN
      presetHold_r     <= CW'(0);
`endif
    end else begin
      // The ring timeout runs regardless of mode; FSM actions below take priority
      if (ringSound_r) begin
        if (ringCount_r == RING_LAST) begin
          ringSound_r <= 1'b0;
          ringCount_r <= RBW'(0);
          if (timerState_r == ST_RING) begin
            timerState_r <= ST_IDLE;
          end
        end else begin
          ringCount_r <= ringCount_r + RBW'(1);
        end
      end

      case (timerState_r)
        ST_IDLE: begin
          if (timerStart_s) begin
            if (bus.presetCentiseconds != CW'(0)) begin
              remainingCount_r <= bus.presetCentiseconds;
              timerState_r     <= ST_RUN;
`ifdef TIMER_AUTO_RELOAD_EN
              presetHold_r     <= bus.presetCentiseconds;
`endif
            end
          end else if (timerSplit_s) begin
            remainingCount_r <= CW'(0);
          end
        end
        ST_RUN: begin
          if (timerStart_s) begin
            timerState_r <= ST_PAUSE;
`ifdef TIMER_AUTO_RELOAD_EN
          end else if (timerSplit_s) begin
            remainingCount_r <= CW'(0);
            timerState_r     <= ST_IDLE;
            ringSound_r      <= 1'b0;
            ringCount_r      <= RBW'(0);
          end else if (remainingCount_r == CW'(0)) begin
            // Zero is shown for one cycle, then the countdown restarts
            remainingCount_r <= presetHold_r;
          end else if (remainingCount_r == CW'(1)) begin
            remainingCount_r <= CW'(0);
            ringSound_r      <= 1'b1;
            ringCount_r      <= RBW'(0);
`else
          end else if (remainingCount_r == CW'(1)) begin
            remainingCount_r <= CW'(0);
            timerState_r     <= ST_RING;
            ringSound_r      <= 1'b1;
            ringCount_r      <= RBW'(0);
`endif
          end else begin
            remainingCount_r <= remainingCount_r - CW'(1);
          end
        end
        ST_PAUSE: begin
          if (timerStart_s) begin
            timerState_r <= ST_RUN;
          end else if (timerSplit_s) begin
            remainingCount_r <= CW'(0);
            timerState_r     <= ST_IDLE;
          end
        end
        ST_RING: begin
          if (timerStart_s || timerSplit_s) begin
            ringSound_r  <= 1'b0;
            ringCount_r  <= RBW'(0);
            timerState_r <= ST_IDLE;
          end
        end
        default: begin
          timerState_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Stopwatch counter, run flag and lap capture
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      swRunning_r      <= 1'b0;
      stopwatchCount_r <= CW'(0);
      lapValue_r       <= CW'(0);
      lapStrobe_r      <= 1'b0;
    end else begin
      lapStrobe_r <= 1'b0;
      if (swRunning_r) begin
        stopwatchCount_r <= stopwatchCount_r + CW'(1);
      end
      if (swStart_s) begin
        swRunning_r <= !swRunning_r;
      end else if (swSplit_s) begin
        if (swRunning_r) begin
          lapValue_r  <= stopwatchCount_r;
          lapStrobe_r <= 1'b1;
        end else begin
          stopwatchCount_r <= CW'(0);
          lapValue_r       <= CW'(0);
        end
      end
    end
  end

  assign bus.mode           = mode_r;
  assign bus.timerState     = timerState_r;
  assign bus.remainingCount = remainingCount_r;
  assign bus.stopwatchCount = stopwatchCount_r;
  assign bus.lapValue       = lapValue_r;
  assign bus.lapStrobe      = lapStrobe_r;
  assign bus.ringSound      = ringSound_r;

endmodule

// File: tb/tb_timer_run_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_run_controller
// Scoreboard bench: the stimulus process steps a behavioural model for every
// clock and queues the expected outputs; a monitor pops one entry after each
// rising edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_timer_run_controller;

  localparam int CW   = 32;
  localparam int DEB  = 2;
  localparam int RING = 500;

  localparam int T_IDLE  = 0;
  localparam int T_RUN   = 1;
  localparam int T_PAUSE = 2;
  localparam int T_RING  = 3;

  typedef struct packed {
    logic [1:0]    mode;
    logic [1:0]    ts;
    logic [CW-1:0] rem;
    logic [CW-1:0] sw;
    logic [CW-1:0] lap;
    logic          strobe;
    logic          ring;
  } exp_t;

  logic          clockSignal;
  logic          resetN;
  logic          mdIn;
  logic          ssIn;
  logic          srIn;
  logic [CW-1:0] preset;

  timer_run_if #(.CW(CW)) bus ();

  assign bus.modeInput          = mdIn;
  assign bus.startOrStop        = ssIn;
  assign bus.splitOrReset       = srIn;
  assign bus.presetCentiseconds = preset;

  timer_run_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .RING_CYCLES(RING),
    .CW(CW)
  ) dut (
    .clockSignal(clockSignal),
    .resetN(resetN),
    .bus(bus)
  );

  initial clockSignal = 1'b0;
  always #5 clockSignal = ~clockSignal;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Behavioural model state
  int            heldFor [3];
  int            mMode;
  int            mTs;
  logic [CW-1:0] mRem;
  int            ringLeft;
  bit            mSwRun;
  logic [CW-1:0] mSw;
  logic [CW-1:0] mLap;
  bit            mStrobe;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Advance the model by one rising edge using the current inputs
  task automatic modelStep();
    bit raw [3];
    bit ev [3];
    bit startP, splitP;
    int m0, ts0;
    bit run0;
    logic [CW-1:0] sw0;
    raw[0] = mdIn; raw[1] = ssIn; raw[2] = srIn;
    if (!resetN) begin
      for (int i = 0; i < 3; i++) heldFor[i] = 0;
      mMode = 0; mTs = T_IDLE; mRem = '0; ringLeft = 0;
      mSwRun = 0; mSw = '0; mLap = '0; mStrobe = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ev[i] = raw[i] && (heldFor[i] + 1 == DEB);
        if (raw[i]) begin
          if (heldFor[i] < DEB) heldFor[i]++;
        end else begin
          heldFor[i] = 0;
        end
      end
      startP = ev[1];
      splitP = ev[2] && !ev[1];
      m0 = mMode; ts0 = mTs; run0 = mSwRun; sw0 = mSw;

      if (ringLeft > 0) begin
        ringLeft--;
        if (ringLeft == 0 && mTs == T_RING) mTs = T_IDLE;
      end
      if (m0 == 0) begin
        case (ts0)
          T_IDLE:  if (startP) begin
                     if (preset != 0) begin mRem = preset; mTs = T_RUN; end
                   end else if (splitP) mRem = '0;
          T_RUN:   if (startP) mTs = T_PAUSE;
                   else if (mRem == 1) begin mRem = '0; mTs = T_RING; ringLeft = RING; end
                   else mRem = mRem - 1;
          T_PAUSE: if (startP) mTs = T_RUN;
                   else if (splitP) begin mRem = '0; mTs = T_IDLE; end
          T_RING:  if (startP || splitP) begin ringLeft = 0; mTs = T_IDLE; end
          default: ;
        endcase
      end else if (ts0 == T_RUN) begin
        if (mRem == 1) begin mRem = '0; mTs = T_RING; ringLeft = RING; end
        else mRem = mRem - 1;
      end

      mStrobe = 0;
      if (run0) mSw = sw0 + 1;
      if (m0 == 1 && startP) mSwRun = !run0;
      else if (m0 == 1 && splitP) begin
        if (run0) begin mLap = sw0; mStrobe = 1; end
        else begin mSw = '0; mLap = '0; end
      end
      if (ev[0]) mMode = (m0 + 1) % 4;
    end
  endtask

  // One clock of stimulus: predict, queue, then move past the edge
  task automatic tick();
    exp_t e;
    modelStep();
    e.mode = 2'(mMode); e.ts = 2'(mTs); e.rem = mRem; e.sw = mSw;
    e.lap = mLap; e.strobe = mStrobe; e.ring = (ringLeft > 0);
    expQ.push_back(e);
    @(negedge clockSignal);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Press a button (0=mode, 1=start, 2=split) for n cycles, then release
  task automatic press(input int btn, input int n);
    if (btn == 0) mdIn = 1'b1; else if (btn == 1) ssIn = 1'b1; else srIn = 1'b1;
    idle(n);
    mdIn = 1'b0; ssIn = 1'b0; srIn = 1'b0;
    tick();
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clockSignal);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("mode",           {30'd0, bus.mode},       {30'd0, e.mode});
        chk("timerState",     {30'd0, bus.timerState}, {30'd0, e.ts});
        chk("remainingCount", bus.remainingCount,      e.rem);
        chk("stopwatchCount", bus.stopwatchCount,      e.sw);
        chk("lapValue",       bus.lapValue,            e.lap);
        chk("lapStrobe",      {31'd0, bus.lapStrobe},  {31'd0, e.strobe});
        chk("ringSound",      {31'd0, bus.ringSound},  {31'd0, e.ring});
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized button activity
  initial begin
    int holdLeft [3];
    resetN = 1'b0; mdIn = 1'b0; ssIn = 1'b0; srIn = 1'b0; preset = 32'd0;
    for (int i = 0; i < 3; i++) heldFor[i] = 0;
    @(negedge clockSignal);
    idle(3);
    resetN = 1'b1;
    idle(2);

    // Debounce and mode wrap
    press(0, 1);
    idle(2);
    press(0, 2);
    press(0, 5);
    press(0, 2);
    press(0, 3);
    idle(2);

    // Countdown of 5 through the full ring timeout
    preset = 32'd5;
    press(1, 2);
    idle(RING + 12);

    // Pause, resume, clear from pause
    preset = 32'd100;
    press(1, 2);
    idle(9);
    press(1, 2);
    idle(5);
    press(1, 2);
    idle(6);
    press(1, 2);
    idle(3);
    press(2, 2);
    idle(3);

    // Stopwatch: lap while running, clear when stopped
    press(0, 2);
    press(1, 2);
    idle(34);
    press(2, 2);
    idle(5);
    press(1, 2);
    idle(2);
    press(2, 2);
    idle(3);

    // Expiry in mode 2: start ignored there, silenced back in mode 0
    press(0, 2); press(0, 2); press(0, 2);
    preset = 32'd20;
    press(1, 2);
    press(0, 2); press(0, 2);
    idle(25);
    press(1, 2);
    idle(3);
    press(0, 2); press(0, 2);
    press(1, 2);
    idle(3);

    // Simultaneous start and split: start wins; then reset mid-run with presses
    preset = 32'd50;
    ssIn = 1'b1; srIn = 1'b1;
    idle(2);
    ssIn = 1'b0; srIn = 1'b0;
    idle(10);
    ssIn = 1'b1; mdIn = 1'b1;
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1; ssIn = 1'b0; mdIn = 1'b0;
    idle(3);

    // Randomized activity
    for (int i = 0; i < 3; i++) holdLeft[i] = 0;
    for (int c = 0; c < 5000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (holdLeft[b] > 0) holdLeft[b]--;
        else if ($urandom_range((b == 0) ? 59 : 11, 0) == 0) holdLeft[b] = $urandom_range(4, 1);
      end
      mdIn = (holdLeft[0] > 0);
      ssIn = (holdLeft[1] > 0);
      srIn = (holdLeft[2] > 0);
      if ($urandom_range(39, 0) == 0) preset = CW'($urandom_range(30, 0));
      resetN = ($urandom_range(1499, 0) != 0);
      tick();
    end
    resetN = 1'b1; mdIn = 1'b0; ssIn = 1'b0; srIn = 1'b0;
    idle(2);

    @(posedge clockSignal);
    #2;
    chk("queue_drained", CW'(expQ.size()), CW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Control sequencer for the 100 Hz timekeeping datapath. Debounces the three front-panel buttons, cycles the display mode, and runs the countdown-timer and stopwatch state machines.
- Owns the remaining-time and elapsed-time counters, the lap capture register and the ring output.
- The clock/date display path reads `mode` and the counters. It does not drive this block.

Parameters:
- DEBOUNCE_CYCLES, 2: consecutive sampled-high cycles needed to accept a press (20 ms at 100 Hz).
- RING_CYCLES, 500: cycles `ringSound` stays high after expiry (5 s).
- CW, 32: width of the centisecond counters.

Ports:
- clockSignal  in  1  100 Hz system clock; all logic on its rising edge.
- resetN  in  1  synchronous, active-low reset.
- modeInput  in  1  raw mode button, active high.
- startOrStop  in  1  raw start/stop button, active high.
- splitOrReset  in  1  raw split/reset button, active high.
- presetCentiseconds  in  CW  countdown preset; sampled only on timer start from IDLE.
- mode  out  2  0=timer, 1=stopwatch, 2=viewClockAndDate, 3=setAlarm.
- timerState  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=RING.
- remainingCount  out  CW  countdown value in centiseconds.
- stopwatchCount  out  CW  stopwatch elapsed centiseconds.
- lapValue  out  CW  last captured split.
- lapStrobe  out  1  one-cycle pulse when `lapValue` is updated.
- ringSound  out  1  alarm drive.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - mode=0, timerState=IDLE.
  - remainingCount, stopwatchCount, lapValue = 0.
  - lapStrobe, ringSound = 0.
  - Debounce counters cleared; stopwatch stopped.
  - Reset overrides every other event in the same cycle.
- Debounce, per button:
  - Counter increments while the raw input is 1 and clears to 0 when it is 0. It saturates at DEBOUNCE_CYCLES.
  - A press event is a one-cycle pulse in the cycle the counter first reaches DEBOUNCE_CYCLES.
  - One event per press; holding the button gives no repeats.
  - Latency from the first high sample to the event: DEBOUNCE_CYCLES cycles.
- Mode press: mode <= mode+1, wrapping 3->0.
  - Changing mode does not stop the timer or the stopwatch; both keep counting in the background.
- Start/stop and split/reset presses act only on the current mode. In modes 2 and 3 they are ignored.
- Timer FSM (mode 0):
  - IDLE + start: if presetCentiseconds != 0, load remainingCount <= presetCentiseconds and go to RUN. If the preset is 0, stay in IDLE.
  - RUN: remainingCount decrements by 1 each cycle. In the cycle it would go 1->0, it becomes 0, the state goes to RING and ringSound rises on the next edge. No underflow is possible.
  - RUN + start -> PAUSE (count frozen). PAUSE + start -> RUN.
  - RING: ringSound=1 for exactly RING_CYCLES cycles, then ringSound=0 and the state goes to IDLE.
  - RING + start or split/reset: silence immediately and go to IDLE.
  - PAUSE or IDLE + split/reset: remainingCount <= 0 and go to IDLE.
  - RUN + split/reset: ignored.
- Stopwatch (mode 1):
  - start toggles running. While running, stopwatchCount increments by 1 per cycle and wraps from 2^CW-1 to 0.
  - split while running: lapValue <= the stopwatchCount value sampled in that cycle (pre-increment). lapStrobe=1 in the next cycle.
  - split while stopped: stopwatchCount <= 0 and lapValue <= 0, with no lapStrobe.
- Simultaneous presses in one cycle:
  - mode is applied after start/split. The start/split action uses the old mode.
  - If start and split arrive together, start wins and split is dropped.
- Timer expiry while mode != 0 still rings; start/split cannot silence it until mode returns to 0. The ring timeout still applies.

Optional Feature:
- Macro TIMER_AUTO_RELOAD_EN.
- Defined: on RUN reaching 0, remainingCount reloads from the last loaded preset (held in an internal register). The state stays in RUN while ringSound pulses for RING_CYCLES, overlapping the new countdown. start -> PAUSE still applies. split in RUN stops the timer: remainingCount=0, state IDLE, ring cleared.
- Undefined: single-shot behaviour exactly as above; no preset-hold register is instantiated.

Test Plan:
- Reset, then hold modeInput high for 1 cycle -> no mode change. Hold it for 2 cycles -> mode 0->1 on the 2nd cycle. Four presses -> mode back to 0.
- Mode 0, preset=5, press start -> remainingCount reaches 0 exactly 5 cycles after the load edge. Then timerState=RING, ringSound=1 for 500 cycles, then IDLE.
- Mode 0, preset=100, start, then start after 10 cycles -> PAUSE with remainingCount=90 held. Start again -> resumes 89, 88, … Split in PAUSE -> remainingCount=0, IDLE.
- Mode 1, start, split at stopwatchCount=37 -> lapValue=37 with a one-cycle lapStrobe. Counting continues. Stop, then split -> both counters 0, no strobe.
- Timer running, switch to mode 2, let it expire -> ringSound=1. Start press in mode 2 -> ignored. Return to mode 0 and press start -> ringSound=0, IDLE.
- resetN low mid-RUN with start and mode pressed in the same cycle -> all outputs at reset values on the next edge. With TIMER_AUTO_RELOAD_EN defined, preset=3 -> remainingCount sequence 3,2,1,0→3 continuously.
